// File: rtl/dest_router_pkg.sv
// Shared definitions for the destination router: FSM state encoding
// and the width of the optional words-routed counters.
package dest_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/dest_router.sv
// dest_router: moves words one at a time from an upstream VC FIFO to one of
// two destination FIFOs, picked by bit DEST_BIT of each word.
// Ports: clk, reset (sync, active-high), en, vc_data/vc_empty/vc_rd (upstream),
//   D0/D1_almost_full, D0/D1_wr, D_data_out (downstream), idle.
// Optional: define DEST_ROUTER_CNT_EN to add D0_count/D1_count counters.
module dest_router
    import dest_router_pkg::*;
#(
    parameter int BW       = 6,
    parameter int DEST_BIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [BW-1:0] vc_data,
    input  logic          vc_empty,
    output logic          vc_rd,
    input  logic          D0_almost_full,
    input  logic          D1_almost_full,
    output logic          D0_wr,
    output logic          D1_wr,
    output logic [BW-1:0] D_data_out,
    output logic          idle
`ifdef DEST_ROUTER_CNT_EN
    ,
    output logic [CNT_W-1:0] D0_count,
    output logic [CNT_W-1:0] D1_count
`endif
);

    state_e        state_q, state_d;
    logic [BW-1:0] hold_q, hold_d;
    logic          rd_ok;
    logic          target;
    logic          blocked;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        vc_rd   = 1'b0;
        D0_wr   = 1'b0;
        D1_wr   = 1'b0;
        rd_ok   = en & ~vc_empty;
        target  = hold_q[DEST_BIT];
        // Flags are used raw so a change lands in the same cycle.
        blocked = target ? D1_almost_full : D0_almost_full;
        // Strobes are forced low during reset so the held word is dropped.
        if (!reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    vc_rd = rd_ok;
                    if (rd_ok) state_d = ST_READ;
                end
                ST_READ: begin
                    hold_d  = vc_data;
                    state_d = ST_SEND;
                end
                ST_SEND: begin
                    if (!blocked) begin
                        D0_wr   = ~target;
                        D1_wr   = target;
                        // Overlap the next read with this write.
                        vc_rd   = rd_ok;
                        state_d = rd_ok ? ST_READ : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign D_data_out = hold_q;
    assign idle       = reset | (state_q == ST_IDLE);

`ifdef DEST_ROUTER_CNT_EN
    logic [CNT_W-1:0] d0_cnt_q, d0_cnt_d;
    logic [CNT_W-1:0] d1_cnt_q, d1_cnt_d;

    always_comb begin
        d0_cnt_d = d0_cnt_q + CNT_W'(D0_wr);
        d1_cnt_d = d1_cnt_q + CNT_W'(D1_wr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d0_cnt_q <= '0;
            d1_cnt_q <= '0;
        end else begin
            d0_cnt_q <= d0_cnt_d;
            d1_cnt_q <= d1_cnt_d;
        end
    end

    assign D0_count = d0_cnt_q;
    assign D1_count = d1_cnt_q;
`endif

endmodule
